// File: rtl/siso_pkg.sv
// Shared definitions for the siso serializer: FSM encoding, idle level default,
// counter sizing helper and an elaboration-time WIDTH guard.
`ifndef SISO_PKG_SV
`define SISO_PKG_SV

`define SISO_CHECK_WIDTH(w) \
  if ((w) < 2) begin : g_width_check \
    $error("siso: WIDTH must be >= 2"); \
  end

package siso_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } siso_state_e;

  localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

  // Gap counter never narrower than one bit, even with no gap configured.
  function automatic int gap_cnt_width(input int gap_cycles);
    int w;
    w = $clog2(gap_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`endif

// File: rtl/siso_hold_reg.sv
// One-entry holding buffer between the load handshake and the shifter.
// A push fills it, a pop empties it; push wins if both occur on the same edge.
module siso_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (pop) begin
      full_d = 1'b0;
    end
    if (push) begin
      full_d = 1'b1;
      data_d = data_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data_out = data_q;
  assign full     = full_q;

endmodule

// File: rtl/siso_word_serializer.sv
// Parallel-to-serial front end: double-buffered word input, one bit per clock out,
// with frame_start/frame_active sideband and optional idle gap between words.
//
// Handshake: a word transfers on a rising edge where load_valid and load_ready are
// both 1; load_ready is !hold_full from registered state only, and the producer must
// keep load_data stable while load_valid=1 and load_ready=0.
module siso_word_serializer
  import siso_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out,
  output logic             frame_start,
  output logic             frame_active,
  output siso_state_e      dbg_state
);

  `SISO_CHECK_WIDTH(WIDTH)

  localparam int CW = $clog2(WIDTH);
  localparam int GW = gap_cnt_width(GAP_CYCLES);
  localparam logic [CW-1:0] LAST_BIT_CNT = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD     = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  siso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             serial_q, serial_d;
  logic             fstart_q, fstart_d;
  logic             factive_q, factive_d;

  logic             hold_full;
  logic             hold_pop;
  logic [WIDTH-1:0] hold_data;
  logic             start_frame;

  siso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clock    (clock),
    .reset    (reset),
    .push     (load_valid && load_ready),
    .pop      (hold_pop),
    .data_in  (load_data),
    .data_out (hold_data),
    .full     (hold_full)
  );

  assign load_ready = !hold_full;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    serial_d    = serial_q;
    fstart_d    = 1'b0;
    factive_d   = factive_q;
    hold_pop    = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start_frame = hold_full;
      end
      ST_SHIFT: begin
        if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - 1'b1;
          if (MSB_FIRST) begin
            serial_d = shift_q[WIDTH-1];
            shift_d  = {shift_q[WIDTH-2:0], 1'b0};
          end else begin
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[WIDTH-1:1]};
          end
        end else if (GAP_CYCLES > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
          serial_d  = IDLE_LEVEL;
          factive_d = 1'b0;
        end else if (hold_full) begin
          start_frame = 1'b1;
        end else begin
          state_d   = ST_IDLE;
          serial_d  = IDLE_LEVEL;
          factive_d = 1'b0;
        end
      end
      ST_GAP: begin
        // Final gap edge behaves exactly like IDLE.
        if (gap_cnt_q == '0) begin
          state_d     = ST_IDLE;
          start_frame = hold_full;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        serial_d  = IDLE_LEVEL;
        factive_d = 1'b0;
      end
    endcase

    // Loading takes the first bit straight from the hold register; the shifter keeps the rest.
    if (start_frame) begin
      hold_pop  = 1'b1;
      state_d   = ST_SHIFT;
      bit_cnt_d = LAST_BIT_CNT;
      fstart_d  = 1'b1;
      factive_d = 1'b1;
      if (MSB_FIRST) begin
        serial_d = hold_data[WIDTH-1];
        shift_d  = {hold_data[WIDTH-2:0], 1'b0};
      end else begin
        serial_d = hold_data[0];
        shift_d  = {1'b0, hold_data[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      serial_q  <= IDLE_LEVEL;
      fstart_q  <= 1'b0;
      factive_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      serial_q  <= serial_d;
      fstart_q  <= fstart_d;
      factive_q <= factive_d;
    end
  end

  assign serial_out   = serial_q;
  assign frame_start  = fstart_q;
  assign frame_active = factive_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_siso_word_serializer.sv
// Directed bench for siso_word_serializer: default instance (MSB first, no gap) and a
// second instance with GAP_CYCLES=2, LSB first. Expected streams are hand-written vectors.
module tb_siso_word_serializer;
  import siso_pkg::*;

  logic        clock;
  logic        reset;
  logic        lv [2];
  logic [7:0]  ld [2];
  logic        ready [2];
  logic        serial [2];
  logic        fstart [2];
  logic        factive [2];
  siso_state_e st [2];

  int          n_checks;
  int          n_fail;
  int          sel;
  logic [7:0]  feed_q[$];

  siso_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (lv[0]),
    .load_ready   (ready[0]),
    .load_data    (ld[0]),
    .serial_out   (serial[0]),
    .frame_start  (fstart[0]),
    .frame_active (factive[0]),
    .dbg_state    (st[0])
  );

  siso_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut_gap (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (lv[1]),
    .load_ready   (ready[1]),
    .load_data    (ld[1]),
    .serial_out   (serial[1]),
    .frame_start  (fstart[1]),
    .frame_active (factive[1]),
    .dbg_state    (st[1])
  );

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: presents the head of feed_q on the selected DUT, pops it on a handshake edge.
  task automatic step();
    logic acc;
    acc = 1'b0;
    if (feed_q.size() > 0) begin
      lv[sel] = 1'b1;
      ld[sel] = feed_q[0];
      acc     = ready[sel];
    end
    @(posedge clock);
    #1;
    if (acc) void'(feed_q.pop_front());
    if (feed_q.size() == 0) lv[sel] = 1'b0;
  endtask

  // Runs n cycles; vector bit n-1 is the expectation for the first cycle.
  task automatic check_seq(input string tag, input int n, input logic [63:0] es,
                           input logic [63:0] est, input logic [63:0] ea, input logic [63:0] er);
    int idx;
    for (int i = 0; i < n; i++) begin
      step();
      idx = n - 1 - i;
      chk($sformatf("%s_serial_c%0d", tag, i), 32'(serial[sel]), 32'(es[idx]));
      chk($sformatf("%s_start_c%0d", tag, i), 32'(fstart[sel]), 32'(est[idx]));
      chk($sformatf("%s_active_c%0d", tag, i), 32'(factive[sel]), 32'(ea[idx]));
      chk($sformatf("%s_ready_c%0d", tag, i), 32'(ready[sel]), 32'(er[idx]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_serial"}, 32'(serial[0]), 32'd0);
    chk({tag, "_ready"}, 32'(ready[0]), 32'd1);
    chk({tag, "_active"}, 32'(factive[0]), 32'd0);
    chk({tag, "_start"}, 32'(fstart[0]), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel      = 0;
    reset    = 1'b0;
    lv[0] = 1'b0; lv[1] = 1'b0;
    ld[0] = 8'h00; ld[1] = 8'h00;

    // 1. reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_reset_outputs($sformatf("reset_c%0d", i));
    end
    chk("reset_state", 32'(st[0]), 32'(ST_IDLE));
    reset = 1'b1;
    step();

    // 2. single word 0xA5
    feed_q.push_back(8'hA5);
    check_seq("a5", 10, 64'b0_10100101_0, 64'b0_10000000_0,
              64'b0_11111111_0, 64'b0_111111111);

    // 3. 0xFF then 0x00 back-to-back
    feed_q.push_back(8'hFF);
    feed_q.push_back(8'h00);
    check_seq("ff00", 18, 64'b0_11111111_00000000_0, 64'b0_10000000_10000000_0,
              64'b0_11111111_11111111_0, 64'b0_1_0000000_111111111);

    // 4. three words with load_valid held high
    feed_q.push_back(8'h11);
    feed_q.push_back(8'h22);
    feed_q.push_back(8'h33);
    check_seq("stream3", 26, 64'b0_00010001_00100010_00110011_0,
              64'b0_10000000_10000000_10000000_0,
              64'b0_11111111_11111111_11111111_0,
              64'b0_1_0000000_1_0000000_111111111);

    // 5. gap instance: LSB first, 2 idle cycles after each word
    sel = 1;
    feed_q.push_back(8'h01);
    feed_q.push_back(8'h01);
    check_seq("gap", 21, 64'b0_10000000_00_10000000_00, 64'b0_10000000_00_10000000_00,
              64'b0_11111111_00_11111111_00, 64'b0_1_000000000_1111111111);
    chk("gap_state_end", 32'(st[1]), 32'(ST_GAP));
    step();
    chk("gap_state_idle", 32'(st[1]), 32'(ST_IDLE));
    sel = 0;

    // 6. reset during bit 4 of 0xC3 with 0xAA waiting in the hold register
    feed_q.push_back(8'hC3);
    feed_q.push_back(8'hAA);
    check_seq("pre_rst", 6, 64'b011000, 64'b010000, 64'b011111, 64'b010000);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    chk("async_rst_state", 32'(st[0]), 32'(ST_IDLE));
    step();
    step();
    check_reset_outputs("rst_hold");
    reset = 1'b1;
    step();
    feed_q.push_back(8'h3C);
    check_seq("post_rst", 12, 64'b0_00111100_000, 64'b0_10000000_000,
              64'b0_11111111_000, 64'b0_11111111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
